// File: rtl/sdram_cmd_issuer.sv
// Purpose: host-side SDRAM command initiator; arbitrates write/read FIFO bursts into READA/WRITEA commands.
// Latency: command registered 1 cycle after IDLE decision; first issue >=2 cycles after Sdram_Init_Done rises.
// Backpressure: command and address held until CMD_ACK; GAP_CYC NOP cycles forced after every ack.
//
// Ports:
//   CLK, RESET (sync, active-high)  Sdram_Init_Done  CMD_ACK (1-cycle ack)
//   WR_FIFO_USEDW / RD_FIFO_USEDW   FIFO fill levels; RD_ENABLE gates read traffic
//   WR_LOAD / RD_LOAD               reload that port's burst address to its BASE
//   CMD (00 NOP, 01 READA, 10 WRITEA), ADDR, WR_GRANT / RD_GRANT (1-cycle pulses),
//   BUSY (state != IDLE), CMD_ERR (sticky ack timeout)
// Optional feature: define CMD_TIMEOUT_EN to enable the ack watchdog and CMD_ERR.
module sdram_cmd_issuer #(
  parameter int               ASIZE      = 23,
  parameter int               UW         = 9,
  parameter int               BURST_LEN  = 8,
  parameter int               FIFO_DEPTH = 512,
  parameter logic [ASIZE-1:0] WR_BASE    = '0,
  parameter logic [ASIZE-1:0] WR_MAX     = 23'h200000,
  parameter logic [ASIZE-1:0] RD_BASE    = '0,
  parameter logic [ASIZE-1:0] RD_MAX     = 23'h200000,
  parameter int               GAP_CYC    = 12,
  parameter int               TIMEOUT    = 1023
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Sdram_Init_Done,
  input  logic             CMD_ACK,
  input  logic [UW-1:0]    WR_FIFO_USEDW,
  input  logic [UW-1:0]    RD_FIFO_USEDW,
  input  logic             RD_ENABLE,
  input  logic             WR_LOAD,
  input  logic             RD_LOAD,
  output logic [1:0]       CMD,
  output logic [ASIZE-1:0] ADDR,
  output logic             WR_GRANT,
  output logic             RD_GRANT,
  output logic             BUSY,
  output logic             CMD_ERR
);

  localparam logic [1:0]       CMD_NOP    = 2'b00;
  localparam logic [1:0]       CMD_READA  = 2'b01;
  localparam logic [1:0]       CMD_WRITEA = 2'b10;
  localparam logic [ASIZE:0]   STEP       = (ASIZE+1)'(BURST_LEN);
  localparam logic [UW-1:0]    WR_THR     = UW'(BURST_LEN);
  localparam logic [UW-1:0]    RD_THR     = UW'(FIFO_DEPTH - BURST_LEN);
  localparam int               GW         = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0]    GAP_LAST   = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {INIT_WAIT, IDLE, ISSUE_WR, ISSUE_RD, GAP} state_t;

  state_t           state;
  logic [ASIZE-1:0] wr_addr;
  logic [ASIZE-1:0] rd_addr;
  logic [ASIZE-1:0] wr_adv;
  logic [ASIZE-1:0] rd_adv;
  logic             prio_wr;
  logic             wr_load_pend;
  logic             rd_load_pend;
  logic [GW-1:0]    gap_cnt;
  logic             wr_rdy;
  logic             rd_rdy;

  // Next burst address; the extra top bit keeps the compare against MAX overflow-free.
  function automatic logic [ASIZE-1:0] advance(input logic [ASIZE-1:0] a,
                                               input logic [ASIZE-1:0] base,
                                               input logic [ASIZE-1:0] max);
    logic [ASIZE:0] s;
    s = {1'b0, a} + STEP;
    if (s >= {1'b0, max}) return base;
    return s[ASIZE-1:0];
  endfunction

  assign wr_adv = advance(wr_addr, WR_BASE, WR_MAX);
  assign rd_adv = advance(rd_addr, RD_BASE, RD_MAX);
  assign wr_rdy = (WR_FIFO_USEDW >= WR_THR);
  assign rd_rdy = RD_ENABLE && (RD_FIFO_USEDW <= RD_THR);
  assign BUSY   = (state != IDLE);

`ifdef CMD_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_hit;
  assign to_hit = (to_cnt == 16'(TIMEOUT - 1));
`else
  assign CMD_ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= INIT_WAIT;
      CMD          <= CMD_NOP;
      ADDR         <= '0;
      WR_GRANT     <= 1'b0;
      RD_GRANT     <= 1'b0;
      wr_addr      <= WR_BASE;
      rd_addr      <= RD_BASE;
      prio_wr      <= 1'b1;
      wr_load_pend <= 1'b0;
      rd_load_pend <= 1'b0;
      gap_cnt      <= '0;
`ifdef CMD_TIMEOUT_EN
      to_cnt       <= '0;
      CMD_ERR      <= 1'b0;
`endif
    end else begin
      WR_GRANT <= 1'b0;
      RD_GRANT <= 1'b0;

      // A port's address is in use only while that port is issuing; otherwise reload at once.
      if (WR_LOAD) begin
        if (state == ISSUE_WR) wr_load_pend <= 1'b1;
        else                   wr_addr      <= WR_BASE;
      end
      if (RD_LOAD) begin
        if (state == ISSUE_RD) rd_load_pend <= 1'b1;
        else                   rd_addr      <= RD_BASE;
      end

      case (state)
        INIT_WAIT: begin
          CMD <= CMD_NOP;
          if (Sdram_Init_Done) state <= IDLE;
        end

        IDLE: begin
          CMD <= CMD_NOP;
`ifdef CMD_TIMEOUT_EN
          to_cnt <= '0;
`endif
          if (!Sdram_Init_Done) begin
            state <= INIT_WAIT;
          end else if (wr_rdy && (!rd_rdy || prio_wr)) begin
            state <= ISSUE_WR;
            CMD   <= CMD_WRITEA;
            ADDR  <= WR_LOAD ? WR_BASE : wr_addr;
            if (rd_rdy) prio_wr <= 1'b0;
          end else if (rd_rdy) begin
            state <= ISSUE_RD;
            CMD   <= CMD_READA;
            ADDR  <= RD_LOAD ? RD_BASE : rd_addr;
            if (wr_rdy) prio_wr <= 1'b1;
          end
        end

        ISSUE_WR, ISSUE_RD: begin
          if (CMD_ACK) begin
            CMD     <= CMD_NOP;
            state   <= GAP;
            gap_cnt <= '0;
            // A load requested during the command wins over the advance.
            if (state == ISSUE_WR) begin
              WR_GRANT     <= 1'b1;
              wr_addr      <= (WR_LOAD || wr_load_pend) ? WR_BASE : wr_adv;
              wr_load_pend <= 1'b0;
            end else begin
              RD_GRANT     <= 1'b1;
              rd_addr      <= (RD_LOAD || rd_load_pend) ? RD_BASE : rd_adv;
              rd_load_pend <= 1'b0;
            end
          end
`ifdef CMD_TIMEOUT_EN
          else if (to_hit) begin
            // Abandon without advancing; the same burst is retried after the gap.
            CMD          <= CMD_NOP;
            CMD_ERR      <= 1'b1;
            state        <= GAP;
            gap_cnt      <= '0;
            wr_load_pend <= 1'b0;
            rd_load_pend <= 1'b0;
            if ((state == ISSUE_WR) && (WR_LOAD || wr_load_pend)) wr_addr <= WR_BASE;
            if ((state == ISSUE_RD) && (RD_LOAD || rd_load_pend)) rd_addr <= RD_BASE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end

        GAP: begin
          CMD <= CMD_NOP;
          if (gap_cnt == GAP_LAST) state <= Sdram_Init_Done ? IDLE : INIT_WAIT;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end

        default: begin
          CMD   <= CMD_NOP;
          state <= INIT_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_issuer.sv
// Purpose: scoreboard bench for sdram_cmd_issuer (write region shrunk to 32 words to reach the wrap).
// Latency: commands are expected in the order pushed; issue spacing is checked where noted.
// Backpressure: an ack responder pulses CMD_ACK a set number of cycles into each command.
module tb_sdram_cmd_issuer;

  localparam int AW = 23;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          Sdram_Init_Done = 1'b0;
  logic          CMD_ACK = 1'b0;
  logic [8:0]    WR_FIFO_USEDW = '0;
  logic [8:0]    RD_FIFO_USEDW = '0;
  logic          RD_ENABLE = 1'b0;
  logic          WR_LOAD = 1'b0;
  logic          RD_LOAD = 1'b0;
  logic [1:0]    CMD;
  logic [AW-1:0] ADDR;
  logic          WR_GRANT, RD_GRANT, BUSY, CMD_ERR;

  always #5 CLK = ~CLK;

  sdram_cmd_issuer #(.WR_MAX(23'd32)) dut (
    .CLK(CLK), .RESET(RESET), .Sdram_Init_Done(Sdram_Init_Done), .CMD_ACK(CMD_ACK),
    .WR_FIFO_USEDW(WR_FIFO_USEDW), .RD_FIFO_USEDW(RD_FIFO_USEDW), .RD_ENABLE(RD_ENABLE),
    .WR_LOAD(WR_LOAD), .RD_LOAD(RD_LOAD), .CMD(CMD), .ADDR(ADDR),
    .WR_GRANT(WR_GRANT), .RD_GRANT(RD_GRANT), .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    int            gap;   // expected NOP cycles before this issue, -1 = unchecked
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] gnt_q[$];   // {WR_GRANT, RD_GRANT}
  exp_t       cur;
  int         checks = 0;
  int         fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic [AW-1:0] a, input int gap, input bit gnt);
    exp_t e;
    e.cmd = c; e.addr = a; e.gap = gap;
    exp_q.push_back(e);
    if (gnt) gnt_q.push_back((c == 2'b10) ? 2'b10 : 2'b01);
  endtask

  // Ack responder: raise CMD_ACK in the ack_dly-th cycle of each command.
  bit ack_en   = 1'b1;
  int ack_dly  = 5;
  int hold_cnt = 0;
  always @(negedge CLK) begin
    if (CMD !== 2'b00 && !RESET) begin
      hold_cnt++;
      CMD_ACK = ack_en && (hold_cnt == ack_dly);
    end else begin
      hold_cnt = 0;
      CMD_ACK  = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every new command and every grant pulse.
  logic [1:0] prev_cmd = 2'b00;
  logic [1:0] prev_gnt = 2'b00;
  int         zero_run = 0;
  always @(negedge CLK) begin
    if (CMD !== 2'b00) begin
      if (prev_cmd === 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_cmd: got cmd %b addr %0h, none expected (t=%0t)", CMD, ADDR, $time);
          cur.cmd = CMD; cur.addr = ADDR; cur.gap = -1;
        end else begin
          cur = exp_q.pop_front();
          check("issue_cmd", 32'(CMD), 32'(cur.cmd));
          check("issue_addr", 32'(ADDR), 32'(cur.addr));
          if (cur.gap >= 0) check("issue_spacing", zero_run, cur.gap);
        end
      end else begin
        check("cmd_addr_hold", {CMD, ADDR}, {cur.cmd, cur.addr});
      end
      zero_run = 0;
    end else begin
      zero_run++;
    end
    prev_cmd = CMD;

    if (prev_gnt != 2'b00) begin
      check("grant_one_cycle", 32'({WR_GRANT, RD_GRANT}), 32'd0);
    end else if (WR_GRANT || RD_GRANT) begin
      if (gnt_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_grant: got wr=%b rd=%b, none expected (t=%0t)", WR_GRANT, RD_GRANT, $time);
      end else begin
        check("grant_port", 32'({WR_GRANT, RD_GRANT}), 32'(gnt_q.pop_front()));
      end
    end
    prev_gnt = {WR_GRANT, RD_GRANT};
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_q_size(input int sz, input int budget, input string name);
    int n = 0;
    while (exp_q.size() > sz && n < budget) begin @(negedge CLK); n++; end
    check(name, exp_q.size(), sz);
    if (exp_q.size() > sz && sz == 0) exp_q.delete();
  endtask

  task automatic wait_gnts(input int budget, input string name);
    int n = 0;
    while (gnt_q.size() != 0 && n < budget) begin @(negedge CLK); n++; end
    check(name, gnt_q.size(), 0);
    gnt_q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    cyc(2);
    RESET = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation bound reached");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset values
    cyc(3);
    check("rst_cmd", 32'(CMD), 32'd0);
    check("rst_addr", 32'(ADDR), 32'd0);
    check("rst_wr_grant", 32'(WR_GRANT), 32'd0);
    check("rst_rd_grant", 32'(RD_GRANT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_cmd_err", 32'(CMD_ERR), 32'd0);
    RESET = 1'b0;

    // Nothing issues before init completes even with a full write FIFO
    WR_FIFO_USEDW = 9'd64;
    cyc(300);
    check("pre_init_cmd", 32'(CMD), 32'd0);
    check("pre_init_busy", 32'(BUSY), 32'd1);

    // Write-only: 5 bursts across the 32-word region wrap to 0; spacing ack+13
    push(2'b10, 23'd0,  -1, 1);
    push(2'b10, 23'd8,  13, 1);
    push(2'b10, 23'd16, 13, 1);
    push(2'b10, 23'd24, 13, 1);
    push(2'b10, 23'd0,  13, 1);
    Sdram_Init_Done = 1'b1;
    cyc(2);
    check("init_to_write_2cyc", 32'(CMD), 32'h2);
    wait_q_size(0, 200, "wr_bursts_issued");
    WR_FIFO_USEDW = 9'd0;
    wait_gnts(40, "wr_bursts_granted");
    cyc(20);
    check("idle_busy", 32'(BUSY), 32'd0);

    // Both ready: strict alternation starting with write
    do_reset();
    WR_FIFO_USEDW = 9'd64;
    RD_ENABLE = 1'b1;
    RD_FIFO_USEDW = 9'd0;
    push(2'b10, 23'd0, -1, 1);
    push(2'b01, 23'd0, 13, 1);
    push(2'b10, 23'd8, 13, 1);
    push(2'b01, 23'd8, 13, 1);
    wait_q_size(0, 200, "alternate_issued");
    WR_FIFO_USEDW = 9'd0;
    RD_ENABLE = 1'b0;
    wait_gnts(40, "alternate_granted");
    cyc(20);

    // Thresholds: write needs >= 8 words, read needs <= 504 words held
    WR_FIFO_USEDW = 9'd7;
    RD_ENABLE = 1'b1;
    RD_FIFO_USEDW = 9'd505;
    cyc(30);
    check("below_threshold_idle", 32'(BUSY), 32'd0);
    push(2'b01, 23'd16, -1, 1);
    RD_FIFO_USEDW = 9'd504;
    wait_q_size(0, 40, "rd_at_threshold_issued");
    RD_FIFO_USEDW = 9'd505;
    wait_gnts(40, "rd_at_threshold_granted");
    push(2'b10, 23'd16, -1, 1);
    WR_FIFO_USEDW = 9'd8;
    wait_q_size(0, 40, "wr_at_threshold_issued");
    WR_FIFO_USEDW = 9'd0;
    RD_ENABLE = 1'b0;
    wait_gnts(40, "wr_at_threshold_granted");
    cyc(20);

    // WR_LOAD during ISSUE_WR at 16 takes effect after the ack
    do_reset();
    ack_dly = 10;
    WR_FIFO_USEDW = 9'd64;
    push(2'b10, 23'd0,  -1, 1);
    push(2'b10, 23'd8,  13, 1);
    push(2'b10, 23'd16, 13, 1);
    push(2'b10, 23'd0,  13, 1);
    wait_q_size(1, 200, "load_reach_addr16");
    WR_LOAD = 1'b1;
    cyc(1);
    WR_LOAD = 1'b0;
    wait_q_size(0, 100, "load_next_write");
    WR_FIFO_USEDW = 9'd0;
    wait_gnts(40, "load_granted");
    cyc(20);

    // WR_LOAD while idle applies immediately (address would otherwise be 8)
    WR_LOAD = 1'b1;
    cyc(1);
    WR_LOAD = 1'b0;
    push(2'b10, 23'd0, -1, 1);
    WR_FIFO_USEDW = 9'd64;
    wait_q_size(0, 40, "idle_load_issued");
    WR_FIFO_USEDW = 9'd0;
    wait_gnts(40, "idle_load_granted");
    cyc(20);

    // Reset mid-command drops CMD and produces no grant
    ack_en = 1'b0;
    push(2'b10, 23'd8, -1, 0);
    WR_FIFO_USEDW = 9'd64;
    wait_q_size(0, 40, "pre_reset_issue");
    cyc(3);
    RESET = 1'b1;
    WR_FIFO_USEDW = 9'd0;
    cyc(1);
    check("reset_mid_cmd", 32'(CMD), 32'd0);
    check("reset_mid_busy", 32'(BUSY), 32'd1);
    RESET = 1'b0;
    ack_en = 1'b1;
    cyc(20);

`ifdef CMD_TIMEOUT_EN
    // No ack: timeout drops CMD, sets CMD_ERR, retries the same address after the gap
    begin
      int n;
      ack_en = 1'b0;
      ack_dly = 5;
      push(2'b10, 23'd0, -1, 0);
      push(2'b10, 23'd0, 13, 1);
      WR_FIFO_USEDW = 9'd64;
      wait_q_size(1, 40, "timeout_first_issue");
      n = 0;
      while (CMD !== 2'b00 && n < 1100) begin @(negedge CLK); n++; end
      check("timeout_cmd_nop", 32'(CMD), 32'd0);
      check("timeout_cmd_err", 32'(CMD_ERR), 32'd1);
      ack_en = 1'b1;
      wait_q_size(0, 40, "timeout_retry");
      WR_FIFO_USEDW = 9'd0;
      wait_gnts(40, "timeout_retry_granted");
      cyc(20);
    end
    check("cmd_err_sticky", 32'(CMD_ERR), 32'd1);
`else
    check("cmd_err_tied_low", 32'(CMD_ERR), 32'd0);
`endif

    check("final_busy", 32'(BUSY), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
